fp_packer: RTL and testbench
============================

Name: fp_packer

Overview:
- Inverse of the float unpack path: takes an unpacked single-precision result (sign, wide signed exponent, extended mantissa with guard/round/sticky, special-case flags) and produces a packed IEEE-754 binary32 word.
- Normalizes, rounds to nearest-even and classifies overflow/underflow.
- Final stage of the fp_adder and CORDIC arithmetic datapaths.
- 3-stage valid/ready pipeline with full backpressure.

Parameters:
- EXP_W, 10, width of signed two's-complement biased input exponent (bias 127).
- MANT_W, 28, input mantissa width; fixed layout below, only 28 is supported.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input beat valid
- in_ready  output  1  pipeline can accept input this cycle
- in_sign  input  1  result sign
- in_exp  input  EXP_W  signed biased exponent; value with hidden bit at in_mant[26] is 2^(in_exp-127)
- in_mant  input  MANT_W  [27] carry, [26] hidden, [25:3] fraction, [2] G, [1] R, [0] S
- in_nan  input  1  force NaN
- in_inf  input  1  force signed infinity
- in_zero  input  1  force signed zero
- out_valid  output  1  packed result valid
- out_ready  input  1  downstream accepts
- out_data  output  32  packed binary32
- out_overflow  output  1  result overflowed to infinity
- out_underflow  output  1  result tiny and inexact, or flushed
- out_inexact  output  1  rounding discarded nonzero bits

Behaviour:
- Reset (async, rst_n=0): all stage valids 0, out_valid=0, out_data=0, all flags 0. In-flight beats are dropped. in_ready=1 in the first cycle after release.
- Handshake:
  - A beat transfers on valid&ready at each boundary.
  - Stage k advances when it is empty or stage k+1 is advancing. in_ready = ~s1_valid | s1_advance (combinational).
  - out_valid, out_data and flags stay stable while out_valid & ~out_ready.
  - Latency 3 cycles with no stall; throughput 1 beat/cycle; ordering preserved; no beat dropped or duplicated.
- S1, normalize:
  - If mant[27]=1: shift right 1, OR the lost bit into S, exp+1.
  - Else: lzc over mant[26:0], shift left by lzc, exp-lzc.
  - mant==0 and no special flag: treat as +/-zero with in_sign.
  - If resulting exp<=0 (tiny): shift right by min(1-exp, 27), OR all lost bits into S, exp=0, set tiny.
- S2, round (RNE):
  - lsb=m[3]; up = G & (R|S|lsb); sum = m[26:3] + up (25 bits).
  - sum[24]=1: shift right 1, exp+1.
  - exp==0 and sum[23]=1 after rounding: exp=1 (subnormal rounds to normal).
  - inexact = G|R|S.
- S3, pack and classify. Priority nan > inf > zero > overflow > normal/subnormal:
  - NaN → 0x7FC00000, flags 0.
  - inf → {sign,8'hFF,23'h0}, flags 0.
  - zero → {sign,31'h0}, flags 0.
  - exp>=255 → {sign,8'hFF,23'h0}, overflow=1, inexact=1.
  - Otherwise {sign, exp[7:0], sum[22:0]}.
  - underflow = tiny & inexact.
- Simultaneous special flags: the highest-priority flag wins.
- Negative exponents deeper than -26: all mantissa bits go to sticky; result is +/-0 or the smallest subnormal, per rounding.

Optional Feature:
- Macro FP_PACKER_FTZ_EN.
- Defined: any tiny result (exp<=0 after normalize) packs to {sign,31'h0} with underflow=1 and inexact=1, regardless of rounding. Subnormal shifter is not built.
- Undefined: gradual underflow as in Behaviour.

Test Plan:
- sign=0, exp=127, mant=0x4000000, out_ready=1 → 3 cycles later out_data=0x3F800000, all flags 0.
- exp=127, mant=0x4000004 (tie, lsb 0) → 0x3F800000, inexact=1. Then mant=0x400000C (tie, lsb 1) → 0x3F800002, inexact=1.
- exp=127, mant=0x7FFFFFC → round carry, 0x40000000, inexact=1. Then exp=254, mant=0x8000000 → 0x7F800000, overflow=1.
- exp=0, mant=0x4000000 → 0x00400000, underflow=0. With FP_PACKER_FTZ_EN → 0x00000000, underflow=1.
- Specials: nan=1 & inf=1 → 0x7FC00000; sign=1, inf=1 → 0xFF800000; sign=1, zero=1 → 0x80000000. Also mant=0 with no flags and sign=1 → 0x80000000.
- Backpressure: stream 6 beats with out_ready=0 for 8 cycles → in_ready low after 3 accepted, out_data stable, then all 6 emerge in order. rst_n pulsed mid-stream → out_valid=0 immediately, no stale beat after release.

Source files
------------

// File: rtl/fp_packer.sv
// fp_packer: 3-stage normalize / round-to-nearest-even / pack into IEEE-754 binary32.
// Define FP_PACKER_FTZ_EN to flush tiny results to signed zero (no subnormal shifter).
module fp_packer #(
   parameter int EXP_W  = 10,
   parameter int MANT_W = 28
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_sign,
   input  logic [EXP_W-1:0]  in_exp,
   input  logic [MANT_W-1:0] in_mant,
   input  logic              in_nan,
   input  logic              in_inf,
   input  logic              in_zero,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_data,
   output logic              out_overflow,
   output logic              out_underflow,
   output logic              out_inexact
);
   localparam int XW = EXP_W + 2;

   logic s1_adv, s2_adv, s3_adv;
   logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d, s3_valid_q, s3_valid_d;

   logic                 s1_sign_q, s1_nan_q, s1_inf_q, s1_zero_q, s1_tiny_q;
   logic                 s1_sign_d, s1_nan_d, s1_inf_d, s1_zero_d, s1_tiny_d;
   logic signed [XW-1:0] s1_exp_q, s1_exp_d;
   logic [26:0]          s1_mant_q, s1_mant_d;

   logic                 s2_sign_q, s2_nan_q, s2_inf_q, s2_zero_q, s2_tiny_q, s2_inexact_q;
   logic                 s2_sign_d, s2_inexact_d;
   logic signed [XW-1:0] s2_exp_q, s2_exp_d;
   logic [22:0]          s2_frac_q, s2_frac_d;

   logic [31:0] s3_data_q, s3_data_d;
   logic        s3_ovf_q, s3_ovf_d, s3_unf_q, s3_unf_d, s3_inx_q, s3_inx_d;

   logic signed [XW-1:0] exp_in, norm_exp;
   logic [26:0]          norm_mant;
   logic [4:0]           lzc;
   logic                 found;
   logic                 up;
   logic [24:0]          sum;
`ifndef FP_PACKER_FTZ_EN
   logic signed [XW-1:0] sh_exp;
   logic [4:0]           sh_amt;
   logic [26:0]          lost_mask, shifted;
`endif

   // Stage k moves when it is empty or the stage after it is moving.
   assign s3_adv   = ~s3_valid_q | out_ready;
   assign s2_adv   = ~s2_valid_q | s3_adv;
   assign s1_adv   = ~s1_valid_q | s2_adv;
   assign in_ready = s1_adv;

   always_comb begin
      s1_valid_d = s1_adv ? in_valid   : s1_valid_q;
      s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
      s3_valid_d = s3_adv ? s2_valid_q : s3_valid_q;
   end

   always_comb begin
      lzc   = 5'd0;
      found = 1'b0;
      for (int i = 26; i >= 0; i--) begin
         if (!found) begin
            if (in_mant[i]) found = 1'b1;
            else            lzc   = lzc + 5'd1;
         end
      end
   end

   assign exp_in = $signed({{2{in_exp[EXP_W-1]}}, in_exp});

   always_comb begin
      if (in_mant[27]) begin
         norm_mant = {in_mant[27:2], in_mant[1] | in_mant[0]};
         norm_exp  = exp_in + XW'(1);
      end else begin
         norm_mant = in_mant[26:0] << lzc;
         norm_exp  = exp_in - $signed({{(XW-5){1'b0}}, lzc});
      end
      s1_sign_d = in_sign;
      s1_nan_d  = in_nan;
      s1_inf_d  = in_inf;
      s1_zero_d = in_zero | (in_mant == '0);
      s1_tiny_d = (norm_exp <= 0);
      s1_exp_d  = norm_exp;
      s1_mant_d = norm_mant;
`ifndef FP_PACKER_FTZ_EN
      sh_exp    = XW'(1) - norm_exp;
      sh_amt    = (sh_exp > XW'(27)) ? 5'd27 : sh_exp[4:0];
      lost_mask = (27'd1 << sh_amt) - 27'd1;
      shifted   = norm_mant >> sh_amt;
`endif
      if (s1_tiny_d) begin
         s1_exp_d = '0;
`ifndef FP_PACKER_FTZ_EN
         // Denormalize: everything shifted out collapses into the sticky bit.
         s1_mant_d = {shifted[26:1], shifted[0] | (|(norm_mant & lost_mask))};
`endif
      end
   end

   always_comb begin
      up           = s1_mant_q[2] & (s1_mant_q[1] | s1_mant_q[0] | s1_mant_q[3]);
      sum          = {1'b0, s1_mant_q[26:3]} + {24'd0, up};
      s2_sign_d    = s1_sign_q;
      s2_inexact_d = |s1_mant_q[2:0];
      s2_exp_d     = s1_exp_q;
      s2_frac_d    = sum[22:0];
      if (sum[24]) begin
         s2_exp_d  = s1_exp_q + XW'(1);
         s2_frac_d = sum[23:1];
      end else if (s1_exp_q == '0 && sum[23]) begin
         s2_exp_d  = XW'(1);
      end
   end

   always_comb begin
      s3_data_d = {s2_sign_q, s2_exp_q[7:0], s2_frac_q};
      s3_ovf_d  = 1'b0;
      s3_unf_d  = s2_tiny_q & s2_inexact_q;
      s3_inx_d  = s2_inexact_q;
      if (s2_nan_q) begin
         s3_data_d = 32'h7FC0_0000;
         {s3_ovf_d, s3_unf_d, s3_inx_d} = 3'b000;
      end else if (s2_inf_q) begin
         s3_data_d = {s2_sign_q, 8'hFF, 23'h0};
         {s3_ovf_d, s3_unf_d, s3_inx_d} = 3'b000;
      end else if (s2_zero_q) begin
         s3_data_d = {s2_sign_q, 31'h0};
         {s3_ovf_d, s3_unf_d, s3_inx_d} = 3'b000;
`ifdef FP_PACKER_FTZ_EN
      end else if (s2_tiny_q) begin
         s3_data_d = {s2_sign_q, 31'h0};
         {s3_ovf_d, s3_unf_d, s3_inx_d} = 3'b011;
`endif
      end else if (s2_exp_q >= XW'(255)) begin
         s3_data_d = {s2_sign_q, 8'hFF, 23'h0};
         {s3_ovf_d, s3_unf_d, s3_inx_d} = 3'b101;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s3_valid_q <= 1'b0;
         {s1_sign_q, s1_nan_q, s1_inf_q, s1_zero_q, s1_tiny_q} <= '0;
         s1_exp_q   <= '0;
         s1_mant_q  <= '0;
         {s2_sign_q, s2_nan_q, s2_inf_q, s2_zero_q, s2_tiny_q, s2_inexact_q} <= '0;
         s2_exp_q   <= '0;
         s2_frac_q  <= '0;
         s3_data_q  <= '0;
         {s3_ovf_q, s3_unf_q, s3_inx_q} <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         s3_valid_q <= s3_valid_d;
         if (s1_adv) begin
            {s1_sign_q, s1_nan_q, s1_inf_q, s1_zero_q, s1_tiny_q} <=
               {s1_sign_d, s1_nan_d, s1_inf_d, s1_zero_d, s1_tiny_d};
            s1_exp_q  <= s1_exp_d;
            s1_mant_q <= s1_mant_d;
         end
         if (s2_adv) begin
            {s2_sign_q, s2_nan_q, s2_inf_q, s2_zero_q, s2_tiny_q, s2_inexact_q} <=
               {s2_sign_d, s1_nan_q, s1_inf_q, s1_zero_q, s1_tiny_q, s2_inexact_d};
            s2_exp_q  <= s2_exp_d;
            s2_frac_q <= s2_frac_d;
         end
         if (s3_adv) begin
            s3_data_q <= s3_data_d;
            {s3_ovf_q, s3_unf_q, s3_inx_q} <= {s3_ovf_d, s3_unf_d, s3_inx_d};
         end
      end
   end

   assign out_valid     = s3_valid_q;
   assign out_data      = s3_data_q;
   assign out_overflow  = s3_ovf_q;
   assign out_underflow = s3_unf_q;
   assign out_inexact   = s3_inx_q;

endmodule

// File: tb/tb_fp_packer.sv
// tb_fp_packer: directed and randomized checks of fp_packer against an exact-arithmetic
// rounding model; honours FP_PACKER_FTZ_EN when the design is built with it.
module tb_fp_packer;
   typedef logic [34:0] res_t;  // {data[31:0], overflow, underflow, inexact}

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, in_sign, in_nan, in_inf, in_zero;
   logic [9:0]  in_exp;
   logic [27:0] in_mant;
   logic        out_valid, out_ready, out_overflow, out_underflow, out_inexact;
   logic [31:0] out_data;

   always #5 clk = ~clk;

   fp_packer dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
      .in_nan(in_nan), .in_inf(in_inf), .in_zero(in_zero),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_overflow(out_overflow), .out_underflow(out_underflow), .out_inexact(out_inexact)
   );

   int   checks = 0, errors = 0;
   int   cyc = 0, out_cnt = 0;
   int   first_in_cyc = -1, first_out_cyc = -1;
   res_t exp_q[$];
   res_t cur_want, held;
   logic hold_pend = 1'b0, last_in_fire = 1'b0;

   task automatic check_val(input string tag, input res_t got, input res_t want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   // Reference: the input is the exact value M * 2^(E-153); round it to binary32 directly.
   function automatic res_t ref_pack(input logic s, input logic [9:0] e10, input logic [27:0] m,
                                     input logic n, input logic inf, input logic z);
      longint E, M, p, be, lsb, q, rem, half, ef;
      logic   tiny, inexact, up;
      if (n)            return {32'h7FC0_0000, 3'b000};
      if (inf)          return {s, 8'hFF, 23'h0, 3'b000};
      if (z || m == 0)  return {s, 31'h0, 3'b000};
      E = longint'($signed(e10));
      M = longint'(m);
      p = 0;
      for (int i = 0; i < 28; i++) if (m[i]) p = i;
      be   = E + p - 26;
      tiny = (be <= 0);
`ifdef FP_PACKER_FTZ_EN
      if (tiny) return {s, 31'h0, 3'b011};
`endif
      lsb = tiny ? (4 - E) : (p - 23);
      if (lsb > 40) begin
         q = 0; inexact = 1'b1; up = 1'b0;
      end else if (lsb > 0) begin
         rem     = M & ((longint'(1) << lsb) - 1);
         half    = longint'(1) << (lsb - 1);
         q       = M >> lsb;
         inexact = (rem != 0);
         up      = (rem > half) || (rem == half && q[0]);
      end else begin
         q = M << (-lsb); inexact = 1'b0; up = 1'b0;
      end
      q = q + longint'(up);
      if (!tiny) begin
         ef = be;
         if (q == (longint'(1) << 24)) begin q = q >> 1; ef = ef + 1; end
      end else begin
         ef = (q >= (longint'(1) << 23)) ? 1 : 0;
      end
      if (ef >= 255) return {s, 8'hFF, 23'h0, 3'b101};
      return {s, ef[7:0], q[22:0], 1'b0, tiny & inexact, inexact};
   endfunction

   function automatic res_t got_now();
      return {out_data, out_overflow, out_underflow, out_inexact};
   endfunction

   // One clock: sample at the falling edge, then return 1 time unit after the rising edge.
   task automatic step();
      res_t g, want;
      @(negedge clk);
      cyc++;
      g = got_now();
      last_in_fire = in_valid & in_ready;
      if (hold_pend) begin
         check_val("hold_valid", {34'd0, out_valid}, 35'd1);
         if (out_valid) check_val("hold_data", g, held);
      end
      hold_pend = 1'b0;
      if (out_valid) begin
         if (out_ready) begin
            if (exp_q.size() == 0) begin
               check_val("spurious_beat", {34'd0, out_valid}, 35'd0);
            end else begin
               want = exp_q.pop_front();
               check_val($sformatf("beat%0d", out_cnt), g, want);
               $display("beat %0d: data=%h ov=%b uf=%b ix=%b (want %h)", out_cnt,
                        out_data, out_overflow, out_underflow, out_inexact, want);
               out_cnt++;
               if (first_out_cyc < 0) first_out_cyc = cyc;
            end
         end else begin
            hold_pend = 1'b1;
            held      = g;
         end
      end
      if (last_in_fire) begin
         exp_q.push_back(cur_want);
         if (first_in_cyc < 0) first_in_cyc = cyc;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_beat(input logic s, input logic [9:0] e, input logic [27:0] m,
                           input logic n, input logic i, input logic z);
      in_sign = s; in_exp = e; in_mant = m; in_nan = n; in_inf = i; in_zero = z;
      cur_want = ref_pack(s, e, m, n, i, z);
   endtask

   task automatic gen_beat();
      logic [9:0]  e;
      logic [27:0] m;
      case ($urandom_range(0, 7))
         0, 1, 2: e = 10'($urandom_range(1, 254));
         3, 4:    e = 10'($urandom_range(0, 40)) - 10'd30;
         5:       e = 10'($urandom_range(240, 275));
         default: e = 10'($urandom);
      endcase
      m = 28'($urandom);
      case ($urandom_range(0, 4))
         0: m[27] = 1'b0;
         1: m = m >> $urandom_range(0, 27);
         2: m = {2'b01, m[25:0]};
         default: ;
      endcase
      if ($urandom_range(0, 40) == 0) m = '0;
      set_beat(1'($urandom), e, m, $urandom_range(0, 24) == 0,
               $urandom_range(0, 24) == 0, $urandom_range(0, 24) == 0);
   endtask

   task automatic drain();
      int g = 0;
      in_valid = 1'b0;
      while (exp_q.size() != 0 && g < 200) begin step(); g++; end
      if (exp_q.size() != 0) check_val("drain_timeout", 35'(exp_q.size()), 35'd0);
   endtask

   task automatic send(input logic s, input logic [9:0] e, input logic [27:0] m,
                       input logic n, input logic i, input logic z, input res_t want);
      int g = 0;
      in_sign = s; in_exp = e; in_mant = m; in_nan = n; in_inf = i; in_zero = z;
      cur_want = want;
      in_valid = 1'b1;
      do begin step(); g++; end while (!last_in_fire && g < 50);
      if (!last_in_fire) check_val("accept_timeout", 35'd0, 35'd1);
      drain();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k, g, sent, c;
      rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      set_beat(1'b0, 10'd0, 28'd0, 1'b0, 1'b0, 1'b0);
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_out", got_now(), '0);
      check_val("rst_valid", {34'd0, out_valid}, 35'd0);
      #2 rst_n = 1'b1;
      #1 check_val("rst_in_ready", {34'd0, in_ready}, 35'd1);

      // Directed vectors
      send(1'b0, 10'd127, 28'h4000000, 1'b0, 1'b0, 1'b0, {32'h3F80_0000, 3'b000});
      check_val("latency", 35'(first_out_cyc - first_in_cyc), 35'd3);
      send(1'b0, 10'd127, 28'h4000004, 1'b0, 1'b0, 1'b0, {32'h3F80_0000, 3'b001});
      send(1'b0, 10'd127, 28'h400000C, 1'b0, 1'b0, 1'b0, {32'h3F80_0002, 3'b001});
      send(1'b0, 10'd127, 28'h7FFFFFC, 1'b0, 1'b0, 1'b0, {32'h4000_0000, 3'b001});
      send(1'b0, 10'd254, 28'h8000000, 1'b0, 1'b0, 1'b0, {32'h7F80_0000, 3'b101});
      send(1'b1, 10'd100, 28'hC000000, 1'b0, 1'b0, 1'b0, {32'hB2C0_0000, 3'b000});
`ifdef FP_PACKER_FTZ_EN
      send(1'b0, 10'd0, 28'h4000000, 1'b0, 1'b0, 1'b0, {32'h0000_0000, 3'b011});
      send(1'b0, 10'd0, 28'h7FFFFF8, 1'b0, 1'b0, 1'b0, {32'h0000_0000, 3'b011});
`else
      send(1'b0, 10'd0, 28'h4000000, 1'b0, 1'b0, 1'b0, {32'h0040_0000, 3'b000});
      send(1'b0, 10'd0, 28'h7FFFFF8, 1'b0, 1'b0, 1'b0, {32'h0080_0000, 3'b011});
`endif
      send(1'b0, 10'h3E2, 28'h4000000, 1'b0, 1'b0, 1'b0, {32'h0000_0000, 3'b011});
      send(1'b0, 10'd127, 28'h4000000, 1'b1, 1'b1, 1'b0, {32'h7FC0_0000, 3'b000});
      send(1'b1, 10'd127, 28'h4000000, 1'b0, 1'b1, 1'b0, {32'hFF80_0000, 3'b000});
      send(1'b1, 10'd127, 28'h4000000, 1'b0, 1'b0, 1'b1, {32'h8000_0000, 3'b000});
      send(1'b1, 10'd50,  28'h0000000, 1'b0, 1'b0, 1'b0, {32'h8000_0000, 3'b000});

      // Backpressure: six beats against a stalled sink for 8 cycles
      out_ready = 1'b0; k = 0;
      for (int cc = 0; cc < 8; cc++) begin
         if (k < 6) begin
            set_beat(1'b0, 10'(120 + k), 28'h4000000 + 28'(k * 8), 1'b0, 1'b0, 1'b0);
            in_valid = 1'b1;
         end
         step();
         if (last_in_fire) k++;
      end
      check_val("bp_accepted", 35'(k), 35'd3);
      check_val("bp_in_ready", {34'd0, in_ready}, 35'd0);
      out_ready = 1'b1; g = 0;
      while (k < 6 && g < 50) begin
         set_beat(1'b0, 10'(120 + k), 28'h4000000 + 28'(k * 8), 1'b0, 1'b0, 1'b0);
         in_valid = 1'b1;
         step(); g++;
         if (last_in_fire) k++;
      end
      check_val("bp_all_sent", 35'(k), 35'd6);
      drain();

      // Reset pulsed with beats in flight
      for (int cc = 0; cc < 4; cc++) begin gen_beat(); in_valid = 1'b1; step(); end
      #2 rst_n = 1'b0;
      #1;
      check_val("midrst_valid", {34'd0, out_valid}, 35'd0);
      check_val("midrst_out", got_now(), '0);
      in_valid = 1'b0; exp_q.delete(); hold_pend = 1'b0;
      @(posedge clk);
      #3 rst_n = 1'b1;
      #1 check_val("midrst_in_ready", {34'd0, in_ready}, 35'd1);
      repeat (6) step();
      check_val("midrst_idle", {34'd0, out_valid}, 35'd0);

      // Randomized traffic with random backpressure
      sent = 0; c = 0; in_valid = 1'b0;
      while (sent < 600 && c < 8000) begin
         if (!in_valid && $urandom_range(0, 3) != 0) begin gen_beat(); in_valid = 1'b1; end
         out_ready = ($urandom_range(0, 9) < 7);
         step(); c++;
         if (last_in_fire) begin sent++; in_valid = 1'b0; end
      end
      check_val("rand_sent", 35'(sent), 35'd600);
      out_ready = 1'b1;
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
